// File: rtl/smvm_stream_tx.sv
// smvm_stream_tx
// Serializes one SMVM frame from a valid/ready upstream into a bubble-free
// word stream: rows, cols, dense vector, then (value, index) pairs with the
// nonzero section zero-padded to a multiple of K. Every frame, normal or
// aborted, is followed by GAP_CYCLES idle cycles so the SMVM can drain and
// reset before the next header arrives.
module smvm_stream_tx #(
   parameter int K          = 4,
   parameter int GAP_CYCLES = 8,
   parameter int MAX_COLS   = 256
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       s_valid,
   output logic       s_ready,
   input  logic [8:0] s_data,
   input  logic [8:0] s_col,
   input  logic       s_row_end,
   input  logic       s_last,
   output logic [7:0] val_out,
   output logic       ipv_out,
   output logic       out_valid,
   output logic       busy,
   output logic       frame_done,
   output logic       err
);

   localparam int NZW = (K > 1) ? $clog2(K) : 1;
   localparam int GCW = $clog2(GAP_CYCLES + 1);
   localparam logic [9:0] MAXC = 10'(MAX_COLS);

   typedef enum logic [2:0] {
      S_IDLE, S_COLS, S_VEC, S_VAL, S_IDX, S_PADV, S_PADI, S_GAP
   } state_t;

   state_t           r_state;
   logic [8:0]       r_cols;
   logic [8:0]       r_vcnt;
   logic [NZW-1:0]   r_nz;
   logic [8:0]       r_col;
   logic             r_last;
   logic [GCW-1:0]   r_gcnt;
   logic [7:0]       r_val;
   logic             r_ipv;
   logic             r_ovld;
   logic             r_done;
   logic             r_err;

   logic [NZW-1:0]   w_nz_inc;
   logic             w_grp_full;
   logic             w_cols_bad;
   logic             w_vec_last;
   logic             w_ipv_eff;

   // Nonzero position within the current K group, wrapping at K.
   assign w_nz_inc   = (r_nz == NZW'(K - 1)) ? '0 : r_nz + NZW'(1);
   assign w_grp_full = (w_nz_inc == '0);
   assign w_cols_bad = (s_data == 9'd0) || ({1'b0, s_data} > MAXC);
   assign w_vec_last = (r_vcnt == r_cols - 9'd1);
   // On the last nonzero the row-end flag is forced to mark the group end:
   // high if the group closes here, low if pad pairs still follow.
   assign w_ipv_eff  = s_last ? w_grp_full : s_row_end;

   assign s_ready    = (r_state == S_IDLE) || (r_state == S_COLS) ||
                       (r_state == S_VEC)  || (r_state == S_VAL);
   assign busy       = (r_state != S_IDLE);
   assign val_out    = r_val;
   assign ipv_out    = r_ipv;
   assign out_valid  = r_ovld;
   assign frame_done = r_done;
   assign err        = r_err;

   // Frame FSM: each transition computes the word shown in the next cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cols  <= '0;
         r_vcnt  <= '0;
         r_nz    <= '0;
         r_col   <= '0;
         r_last  <= 1'b0;
         r_gcnt  <= '0;
         r_val   <= '0;
         r_ipv   <= 1'b0;
         r_ovld  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_val  <= '0;
         r_ipv  <= 1'b0;
         r_ovld <= 1'b0;
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (s_valid) begin
                  {r_val, r_ipv} <= s_data;
                  r_ovld  <= 1'b1;
                  r_vcnt  <= '0;
                  r_nz    <= '0;
                  r_last  <= 1'b0;
                  r_state <= S_COLS;
               end
            end
            S_COLS: begin
               if (s_valid && !w_cols_bad) begin
                  {r_val, r_ipv} <= s_data;
                  r_ovld  <= 1'b1;
                  r_cols  <= s_data;
                  r_vcnt  <= '0;
                  r_state <= S_VEC;
               end else begin
                  // Missing or illegal shape: abort; the low cycle just
                  // started counts as the first gap cycle.
                  if (s_valid) r_cols <= s_data;
                  r_err   <= 1'b1;
                  r_gcnt  <= GCW'(1);
                  r_state <= S_GAP;
               end
            end
            S_VEC: begin
               if (s_valid) begin
                  r_val   <= s_data[7:0];
                  r_ovld  <= 1'b1;
                  r_vcnt  <= r_vcnt + 9'd1;
                  if (w_vec_last) r_state <= S_VAL;
               end else begin
                  r_err   <= 1'b1;
                  r_gcnt  <= GCW'(1);
                  r_state <= S_GAP;
               end
            end
            S_VAL: begin
               if (s_valid) begin
                  r_val   <= s_data[7:0];
                  r_ipv   <= w_ipv_eff;
                  r_ovld  <= 1'b1;
                  r_col   <= s_col;
                  r_last  <= s_last;
                  r_nz    <= w_nz_inc;
                  r_state <= S_IDX;
               end else begin
                  r_err   <= 1'b1;
                  r_gcnt  <= GCW'(1);
                  r_state <= S_GAP;
               end
            end
            S_IDX: begin
               {r_val, r_ipv} <= r_col;
               r_ovld <= 1'b1;
               if (r_last && r_nz == '0) begin
                  r_gcnt  <= '0;
                  r_state <= S_GAP;
               end else if (r_last) begin
                  r_state <= S_PADV;
               end else begin
                  r_state <= S_VAL;
               end
            end
            S_PADV: begin
               r_ipv   <= w_grp_full;
               r_ovld  <= 1'b1;
               r_nz    <= w_nz_inc;
               r_state <= S_PADI;
            end
            S_PADI: begin
               r_ovld <= 1'b1;
               if (r_nz == '0) begin
                  r_gcnt  <= '0;
                  r_state <= S_GAP;
               end else begin
                  r_state <= S_PADV;
               end
            end
            S_GAP: begin
               // Count 0 only occurs after a normal finish, while the final
               // word is still on the bus; done lands on the first idle cycle.
               if (r_gcnt == '0) r_done <= 1'b1;
               if (r_gcnt == GCW'(GAP_CYCLES)) begin
                  r_gcnt  <= '0;
                  r_state <= S_IDLE;
               end else begin
                  r_gcnt  <= r_gcnt + GCW'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_smvm_stream_tx.sv
// Scoreboard bench for smvm_stream_tx: frame procedures push hand-computed
// expected words/events, a negedge monitor pops and compares whatever the
// DUT presents, and independently measures frame length and idle gaps.
module tb_smvm_stream_tx;

   localparam int GAP = 8;
   localparam int K_WORD = 0, K_DONE = 1, K_ERR = 2;

   typedef struct {
      int         kind;
      logic [7:0] v;
      logic       p;
      int         len;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       s_valid = 1'b0;
   logic       s_ready;
   logic [8:0] s_data = '0;
   logic [8:0] s_col = '0;
   logic       s_row_end = 1'b0;
   logic       s_last = 1'b0;
   logic [7:0] val_out;
   logic       ipv_out, out_valid, busy, frame_done, err;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   run = 0;
   int   lowrun = 0;
   int   nword = 0;

   smvm_stream_tx #(.K(4), .GAP_CYCLES(GAP), .MAX_COLS(256)) dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
      .s_data(s_data), .s_col(s_col), .s_row_end(s_row_end), .s_last(s_last),
      .val_out(val_out), .ipv_out(ipv_out), .out_valid(out_valid),
      .busy(busy), .frame_done(frame_done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   task automatic pw(input int v, input int p);
      exp_t e;
      e.kind = K_WORD; e.v = 8'(v); e.p = 1'(p); e.len = 0;
      q.push_back(e);
   endtask

   task automatic pev(input int kind, input int len);
      exp_t e;
      e.kind = kind; e.v = '0; e.p = 1'b0; e.len = len;
      q.push_back(e);
   endtask

   // Present one upstream word and hold it until accepted (bounded).
   task automatic drive(input int d, input int c, input int re, input int last);
      int n;
      n = 0;
      s_valid = 1'b1; s_data = 9'(d); s_col = 9'(c);
      s_row_end = 1'(re); s_last = 1'(last);
      @(negedge clk);
      while (!s_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready) begin
         checks++; errors++;
         $display("FAIL accept_timeout: s_ready=0 want 1 (data %0d)", d);
      end
      @(posedge clk); #1;
   endtask

   // Release the upstream and wait for the DUT to be back in IDLE (bounded).
   task automatic wait_ready();
      int n;
      n = 0;
      s_valid = 1'b0; s_last = 1'b0; s_row_end = 1'b0;
      @(negedge clk);
      while (!s_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready) begin
         checks++; errors++;
         $display("FAIL idle_timeout: s_ready=0 want 1");
      end
      @(posedge clk); #1;
   endtask

   task automatic basic_frame();
      pw(1,0); pw(1,1); pw(5,0); pw(6,0); pw(7,0);
      pw(3,0); pw(0,0); pw(4,1); pw(1,0); pw(9,0); pw(0,1);
      pw(0,1); pw(0,0);
      pev(K_DONE, 13);
      drive(2, 0, 0, 0);
      drive(3, 0, 0, 0);
      drive(5, 0, 1, 0);
      drive(6, 0, 0, 0);
      drive(7, 0, 1, 1);   // s_last outside VAL must be ignored
      drive(3, 0, 0, 0);
      drive(4, 2, 1, 0);
      drive(9, 1, 1, 1);
   endtask

   task automatic exact_frame();
      pw(0,1); pw(0,1); pw(10,0);
      pw(11,0); pw(1,1); pw(12,1); pw(2,0);
      pw(13,0); pw(2,1); pw(14,1); pw(150,0);
      pev(K_DONE, 11);
      drive(1, 0, 0, 0);
      drive(1, 0, 0, 0);
      drive(10, 0, 0, 0);
      drive(11, 3, 0, 0);
      drive(12, 4, 1, 0);
      drive(13, 5, 0, 0);
      drive(14, 300, 0, 1);
   endtask

   // Monitor: pop and compare on every word/event, track run and gap lengths.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         run = 0;
         lowrun = 0;
      end else begin
         if (out_valid || frame_done || err) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_output: ov=%0b val=%0d ipv=%0b done=%0b err=%0b, want nothing",
                        out_valid, val_out, ipv_out, frame_done, err);
            end else begin
               e = q.pop_front();
               if (out_valid) begin
                  nword++;
                  if (e.kind != K_WORD || val_out != e.v || ipv_out != e.p || frame_done || err) begin
                     errors++;
                     $display("FAIL word%0d: got val=%0d ipv=%0b (done=%0b err=%0b), want kind=%0d val=%0d ipv=%0b",
                              nword, val_out, ipv_out, frame_done, err, e.kind, e.v, e.p);
                  end
               end else if (frame_done) begin
                  if (e.kind != K_DONE || run != e.len || err) begin
                     errors++;
                     $display("FAIL frame_done: got run=%0d err=%0b, want kind=%0d run=%0d",
                              run, err, e.kind, e.len);
                  end
               end else begin
                  if (e.kind != K_ERR) begin
                     errors++;
                     $display("FAIL err_pulse: got err pulse, want kind=%0d", e.kind);
                  end
               end
            end
         end
         if (out_valid) run++; else run = 0;
         if (!out_valid && !s_ready) begin
            lowrun++;
         end else begin
            if (lowrun > 0 && s_ready) begin
               checks++;
               if (lowrun != GAP) begin
                  errors++;
                  $display("FAIL gap_len: got %0d idle cycles, want %0d", lowrun, GAP);
               end
            end
            lowrun = 0;
         end
      end
   end

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_val_out", val_out, 0);
      chk("rst_ipv_out", ipv_out, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_err", err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_s_ready", s_ready, 1);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic frame with padding
      basic_frame();
      wait_ready();

      // Exact multiple of K, no pad
      exact_frame();
      wait_ready();

      // Underrun mid-vector, then a clean frame
      pw(1,0); pw(2,0); pw(1,0); pw(2,0); pev(K_ERR, 0);
      drive(2, 0, 0, 0);
      drive(4, 0, 0, 0);
      drive(1, 0, 0, 0);
      drive(2, 0, 0, 0);
      s_valid = 1'b0;
      @(posedge clk); #1;
      wait_ready();
      basic_frame();
      wait_ready();

      // Bad shapes
      pw(1,1); pev(K_ERR, 0);
      drive(3, 0, 0, 0);
      drive(0, 0, 0, 0);
      wait_ready();
      pw(1,1); pev(K_ERR, 0);
      drive(3, 0, 0, 0);
      drive(300, 0, 0, 0);
      wait_ready();

      // Back-to-back with upstream held valid
      basic_frame();
      exact_frame();
      wait_ready();

      // Asynchronous reset while in VAL
      pw(0,1); pw(0,1);
      drive(1, 0, 0, 0);
      drive(1, 0, 0, 0);
      drive(8, 0, 0, 0);
      chk("busy_in_val", busy, 1);
      rst_n = 1'b0;
      s_valid = 1'b0;
      @(negedge clk);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_val_out", val_out, 0);
      chk("mid_rst_busy", busy, 0);
      @(negedge clk);
      chk("mid_rst_s_ready", s_ready, 1);
      chk("mid_rst_queue", q.size(), 0);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      basic_frame();
      wait_ready();

      repeat (3) @(negedge clk);
      chk("final_queue_empty", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/smvm_stream_tx.md
# smvm_stream_tx

Frame serializer that drives the input port of the sparse matrix-vector multiplier (SMVM): `val_in`, `ipv_in` and `in_valid`. It accepts one frame from an upstream valid/ready source and emits it as a contiguous word stream: shape header, dense vector, then nonzero value/index pairs. It zero-pads the nonzero section to a multiple of K and enforces the inter-frame idle gap the SMVM needs to finish and reset.

## Interface
- K, 4: ALU group size; nonzero count is padded to a multiple of K.
- GAP_CYCLES, 8: idle cycles (`out_valid` = 0) after each frame; must be ≥ 7.
- MAX_COLS, 256: largest legal cols value.
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- s_valid  in  1  upstream word valid.
- s_ready  out  1  upstream word accepted when s_valid & s_ready at a rising edge.
- s_data  in  9  rows (in phase ROWS), cols (in phase COLS), vector element or nonzero value (bits [7:0]).
- s_col  in  9  nonzero column index; sampled in VAL only.
- s_row_end  in  1  nonzero is the last one of its row; sampled in VAL only.
- s_last  in  1  final nonzero of the frame; sampled in VAL only.
- val_out  out  8  to SMVM `val_in`.
- ipv_out  out  1  to SMVM `ipv_in`.
- out_valid  out  1  to SMVM `in_valid`.
- busy  out  1  state ≠ IDLE.
- frame_done  out  1  one-cycle pulse on normal frame completion.
- err  out  1  one-cycle pulse on abort.

## Operation
- States: IDLE, COLS, VEC, VAL, IDX, PADV, PADI, GAP.
- s_ready is decoded from state: 1 in IDLE, COLS, VEC, VAL; 0 otherwise.
- val_out, ipv_out and out_valid are registered. A word is computed on the transition and presented in the following cycle.
- 9-bit words are emitted as {val_out, ipv_out} = word[8:1], word[0].
- **IDLE:** on accept, emit rows as a 9-bit word, then go to COLS. With no s_valid, stay in IDLE and emit nothing.
- **COLS:** on accept, capture cols.
  - If cols = 0 or cols > MAX_COLS: err pulse, out_valid = 0, go to GAP.
  - Otherwise emit cols, clear vcnt, go to VEC.
- **VEC:** on accept, emit {s_data[7:0], 0} and increment vcnt. When vcnt = cols−1, go to VAL.
- **VAL:** on accept:
  - Emit {s_data[7:0], ipv_eff}, latch s_col and s_last, nz = (nz+1) mod K, go to IDX.
  - ipv_eff = s_row_end, except 0 when s_last and the new nz ≠ 0 (padding needed).
  - If s_last is set, ipv_eff is 1 whenever no padding follows, regardless of s_row_end.
- **IDX:** emit the latched col as a 9-bit word.
  - Latched last and nz = 0: go to GAP with frame_done.
  - Latched last and nz ≠ 0: go to PADV.
  - Otherwise: go to VAL.
- **PADV:** emit {0, p}, where p = 1 only when this pad completes the group (nz+1 mod K = 0). Update nz, go to PADI.
- **PADI:** emit index word 0. If nz = 0, go to GAP with frame_done; otherwise go to PADV.
- **GAP:** out_valid = 0, s_ready = 0, count GAP_CYCLES cycles, then go to IDLE.
- **Underrun:** s_valid = 0 in COLS, VEC or VAL gives an err pulse, out_valid = 0 next cycle, and a transition to GAP (frame aborted). The SMVM sees in_valid fall.
- s_last is ignored outside VAL.
- Reset: state IDLE; val_out = 0, ipv_out = 0, out_valid = 0, frame_done = 0, err = 0; all counters 0. s_ready reads 1 in IDLE.
- Reset mid-frame aborts immediately; no gap is generated.

## Timing
- Accept at edge T puts the word on the outputs during cycle T+1.
- out_valid stays high with no bubbles from the rows word to the last index/pad word.
- Nonzero throughput is one accept per 2 cycles: s_ready is low in IDX, PADV and PADI.
- Frame length in valid cycles = 2 + cols + 2·ceil(nnz/K)·K.
- After the final word: GAP_CYCLES low cycles, then s_ready = 1.
- frame_done is asserted in the first GAP cycle.
- err is asserted in the cycle after the failing condition.

## Test plan
- **Basic frame:** rows = 2, cols = 3, vec 5,6,7; nonzeros (3,c0,re0), (4,c2,re1), (9,c1,re1,last) -> out words (val,ipv):
  - Header and vector: (1,0), (1,1), (5,0), (6,0), (7,0).
  - Nonzeros: (3,0), (0,0), (4,1), (1,0), (9,0), (0,1).
  - Pad: (0,1), (0,0).
  - Then 8 idle cycles; frame_done in the first idle cycle.
- **Exact multiple:** 4 nonzeros with last → no pad words; ipv of the 4th value = 1; 8 nonzero-section cycles.
- **Underrun:** drop s_valid for 1 cycle mid-vector (cols = 4, after 2 elements) -> err pulse, out_valid low from the next cycle, GAP, then IDLE accepts a new frame.
- **Bad shape:** cols = 0, then cols = 300 -> err pulse each time, no vector words emitted.
- **Back-to-back frames:** upstream always valid -> s_ready low exactly GAP_CYCLES cycles between frames; the second frame is bit-exact.
- **Async reset in VAL:** outputs are 0 during reset; the next frame after release starts with the rows word.
